// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and valid/ack handshake.
// Latency: byte visible (valid=1) one cycle after the mid-stop-bit sample; pin-to-decision lag is 2 cycles (synchroniser).
// Backpressure: none on the line; an unconsumed byte is overwritten and flagged as overrun.
//
// Ports:
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   uart_rxd          serial line, idle high, asynchronous to clk
//   uart_rx_ack       consumer strobe; clears uart_rx_valid and uart_rx_overrun
//   uart_rx_data      last correctly framed byte
//   uart_rx_valid     high while uart_rx_data holds an unconsumed byte
//   uart_rx_busy      high while a frame is in progress (FSM not idle)
//   uart_rx_frame_err one-cycle pulse when the stop bit samples 0
//   uart_rx_overrun   sticky; a new byte overwrote an unconsumed one
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    input  logic       uart_rx_ack,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_busy,
    output logic       uart_rx_frame_err,
    output logic       uart_rx_overrun
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          fe_q, fe_d;
    logic          ovr_q, ovr_d;
    logic          load;
    logic          rxd_s;

    assign rxd_s = sync2_q;

    // Synchroniser resets to the idle (high) line level so reset release
    // never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: counter free-runs inside a bit and is cleared at every
    // sample point, so each sample lands CLKS_PER_BIT after the previous one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        fe_d    = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again mid-start-bit was only a glitch.
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Absorbs a break so it raises only a single frame error.
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Holding register and handshake. A load with a coincident ack means the
    // old byte was consumed, so no overrun is recorded.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (load) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (uart_rx_ack) begin
                ovr_d = 1'b0;
            end else if (valid_q) begin
                ovr_d = 1'b1;
            end
        end else if (uart_rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_busy      = busy_q;
    assign uart_rx_frame_err = fe_q;
    assign uart_rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Latency: frames are driven from the bench clock; observations are taken 1 time unit after each rising edge.
// Backpressure: ack is driven directly by the bench at chosen frame offsets.
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       uart_rxd;
    logic       uart_rx_ack;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_busy;
    logic       uart_rx_frame_err;
    logic       uart_rx_overrun;

    int checks = 0;
    int errors = 0;

    // Per-frame observations, as offsets (in clocks) from the first driven
    // start-bit cycle; -1 when the event was not seen.
    int v_rise, v_fall, b_rise, b_fall, fe_cnt, busy_cnt;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .uart_rxd          (uart_rxd),
        .uart_rx_ack       (uart_rx_ack),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_busy      (uart_rx_busy),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_overrun   (uart_rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (uart_rx_busy) busy_cnt++;
            if (uart_rx_frame_err) fe_cnt++;
        end
    endtask

    // Drives the first ncyc clocks of an 8N1 frame at 16 clocks/bit. ack is
    // high for the single cycle whose driven offset equals ack_off.
    task automatic send(input logic [7:0] b, input logic stopb, input int ncyc, input int ack_off);
        int   slot;
        logic pv, pb;
        v_rise = -1; v_fall = -1; b_rise = -1; b_fall = -1;
        fe_cnt = 0; busy_cnt = 0;
        for (int j = 0; j < ncyc; j++) begin
            slot = j / 16;
            if (slot == 0)      uart_rxd = 1'b0;
            else if (slot <= 8) uart_rxd = b[slot-1];
            else                uart_rxd = stopb;
            uart_rx_ack = (j == ack_off);
            pv = uart_rx_valid;
            pb = uart_rx_busy;
            @(posedge clk);
            #1;
            if (!pv && uart_rx_valid && v_rise < 0) v_rise = j + 1;
            if (pv && !uart_rx_valid && v_fall < 0) v_fall = j + 1;
            if (!pb && uart_rx_busy && b_rise < 0)  b_rise = j + 1;
            if (pb && !uart_rx_busy && b_fall < 0)  b_fall = j + 1;
            if (uart_rx_frame_err) fe_cnt++;
            if (uart_rx_busy) busy_cnt++;
        end
        uart_rx_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        uart_rx_ack = 1'b1;
        @(posedge clk);
        #1;
        uart_rx_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        uart_rxd    = 1'b1;
        uart_rx_ack = 1'b0;
        #1;
        chk("rst_data",  uart_rx_data, 8'h00);
        chk("rst_valid", uart_rx_valid, 1'b0);
        chk("rst_busy",  uart_rx_busy, 1'b0);
        chk("rst_fe",    uart_rx_frame_err, 1'b0);
        chk("rst_ovr",   uart_rx_overrun, 1'b0);
        tick(3);
        reset_n = 1'b1;
        tick(5);

        // 1: single byte 0xA5, no ack.
        send(8'hA5, 1'b1, 160, -1);
        chk("t1_data",   uart_rx_data, 8'hA5);
        chk("t1_valid",  uart_rx_valid, 1'b1);
        chk("t1_vrise",  v_rise, 155);
        chk("t1_brise",  b_rise, 3);
        chk("t1_bfall",  b_fall, 155);
        chk("t1_fe",     fe_cnt, 0);
        tick(20);
        chk("t1_hold",   uart_rx_valid, 1'b1);

        // 2: 0x00 then 0xFF, each frame acking the previous byte early on.
        send(8'h00, 1'b1, 160, 2);
        chk("t2a_vfall", v_fall, 3);
        chk("t2a_vrise", v_rise, 155);
        chk("t2a_data",  uart_rx_data, 8'h00);
        send(8'hFF, 1'b1, 160, 2);
        chk("t2b_vfall", v_fall, 3);
        chk("t2b_vrise", v_rise, 155);
        chk("t2b_data",  uart_rx_data, 8'hFF);
        chk("t2_ovr",    uart_rx_overrun, 1'b0);
        ack_pulse();
        chk("t2_ackclr", uart_rx_valid, 1'b0);

        // 3: 4-cycle low glitch.
        busy_cnt = 0; fe_cnt = 0;
        uart_rxd = 1'b0;
        tick(4);
        uart_rxd = 1'b1;
        tick(26);
        chk("t3_busylen", (busy_cnt >= 1 && busy_cnt <= 9), 1'b1);
        chk("t3_busy",    uart_rx_busy, 1'b0);
        chk("t3_valid",   uart_rx_valid, 1'b0);
        chk("t3_fe",      fe_cnt, 0);
        chk("t3_data",    uart_rx_data, 8'hFF);

        // 4: 0x3C with a 0 stop bit, then a 48-cycle break.
        send(8'h3C, 1'b0, 160, -1);
        busy_cnt = 0;
        tick(48);
        chk("t4_busyhold", busy_cnt, 48);
        uart_rxd = 1'b1;
        tick(4);
        chk("t4_fe",     fe_cnt, 1);
        chk("t4_busy",   uart_rx_busy, 1'b0);
        chk("t4_valid",  uart_rx_valid, 1'b0);
        chk("t4_data",   uart_rx_data, 8'hFF);

        // 5: overrun, then ack coincident with the second load.
        send(8'h11, 1'b1, 160, -1);
        chk("t5_ovr0",   uart_rx_overrun, 1'b0);
        send(8'h22, 1'b1, 160, -1);
        chk("t5_data",   uart_rx_data, 8'h22);
        chk("t5_valid",  uart_rx_valid, 1'b1);
        chk("t5_ovr",    uart_rx_overrun, 1'b1);
        ack_pulse();
        chk("t5_vclr",   uart_rx_valid, 1'b0);
        chk("t5_oclr",   uart_rx_overrun, 1'b0);
        ack_pulse();
        chk("t5_idleack", uart_rx_data, 8'h22);
        chk("t5_idlevld", uart_rx_valid, 1'b0);
        send(8'h11, 1'b1, 160, -1);
        send(8'h22, 1'b1, 160, 154);
        chk("t5b_data",  uart_rx_data, 8'h22);
        chk("t5b_valid", uart_rx_valid, 1'b1);
        chk("t5b_ovr",   uart_rx_overrun, 1'b0);

        // 6: reset in the middle of bit 3 of 0x5A, then a clean 0xC3.
        send(8'h5A, 1'b1, 72, -1);
        chk("t6_midbusy", uart_rx_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t6_data",   uart_rx_data, 8'h00);
        chk("t6_valid",  uart_rx_valid, 1'b0);
        chk("t6_busy",   uart_rx_busy, 1'b0);
        chk("t6_fe",     uart_rx_frame_err, 1'b0);
        chk("t6_ovr",    uart_rx_overrun, 1'b0);
        uart_rxd = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(5);
        chk("t6_idle",   uart_rx_busy, 1'b0);
        send(8'hC3, 1'b1, 160, -1);
        chk("t6b_data",  uart_rx_data, 8'hC3);
        chk("t6b_valid", uart_rx_valid, 1'b1);
        chk("t6b_vrise", v_rise, 155);
        chk("t6b_fe",    fe_cnt, 0);
        chk("t6b_ovr",   uart_rx_overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the sum/latch system's UART transmitter.
- Deserialises bytes arriving on uart_rxd and presents them in a one-entry holding register with a valid/ack handshake.
- Reports framing errors and overrun.
- Sits between the board-level RX pin and the command/operand logic that loads the A/B operands remotely.

Parameters:
CLKS_PER_BIT, 1042, system clocks per bit period (10 MHz / 9600 baud); legal range 8..65535.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
uart_rxd  input  1  serial line, idle high, asynchronous to clk.
uart_rx_ack  input  1  consumer strobe; clears uart_rx_valid and uart_rx_overrun.
uart_rx_data  output  8  last correctly framed byte.
uart_rx_valid  output  1  level; high while uart_rx_data holds an unconsumed byte.
uart_rx_busy  output  1  high while a frame is being received (FSM not in IDLE).
uart_rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0.
uart_rx_overrun  output  1  sticky; a new byte overwrote an unconsumed one.

Behaviour:
- Reset values (asynchronous, immediate): uart_rx_data=0x00; valid, busy, frame_err and overrun = 0; synchroniser flops = 1; FSM = IDLE; bit counter and cycle counter = 0.
- Input synchronisation: uart_rxd passes through a 2-flop synchroniser (rxd_s). All decisions use rxd_s, which lags the pin by 2 cycles.
- Let HALF = (CLKS_PER_BIT-1)/2, using integer division.
- Cycle counter is wide enough for CLKS_PER_BIT-1.
- Let D be the first cycle in IDLE with rxd_s=0.
- FSM states and transitions:
  - IDLE: on rxd_s=0 -> START, cycle counter cleared.
  - START: sample at D+1+HALF.
    - If rxd_s=1, the start bit was a glitch -> IDLE, no flags.
    - Otherwise -> DATA.
  - DATA: bit k (k=0..7, LSB first) is sampled at D+1+HALF+(k+1)*CLKS_PER_BIT and shifted into the shift register. After bit 7 -> STOP.
  - STOP: sample at D+1+HALF+9*CLKS_PER_BIT.
    - If rxd_s=1: load uart_rx_data from the shift register and set valid, registered on the next cycle; -> IDLE.
    - If rxd_s=0: pulse frame_err for exactly 1 cycle; holding register and valid are untouched; -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then -> IDLE. This absorbs break conditions, so only one frame_err is raised per break.
- uart_rx_busy = 1 in START, DATA, STOP and WAIT_HIGH; 0 only in IDLE. It is registered.
- A new start bit is accepted on the first IDLE cycle after returning from STOP. This allows back-to-back frames with a single stop bit.
- Handshake:
  - uart_rx_ack=1 clears valid and overrun on the next cycle.
  - An ack while valid=0 has no effect.
- Load while valid=1 and no ack in the same cycle: data is overwritten with the new byte, valid stays 1, overrun is set.
- Load and ack in the same cycle: the new byte is loaded, valid stays 1, overrun is cleared (the old byte was consumed).
- Overrun stays set until an ack cycle that has no simultaneous un-acked overwrite.
- Reset asserted mid-frame aborts the frame immediately, with all outputs at reset values. After release, the receiver waits in IDLE for a fresh falling edge.

Test Plan:
Benches run with CLKS_PER_BIT=16 (HALF=7).
1. Send 0xA5, 8N1, at exactly 16 clk/bit -> uart_rx_data=0xA5; valid rises 1 cycle after the stop sample (D+152) and holds with no ack; busy high from D+1 through the stop sample; frame_err stays 0.
2. Send 0x00 then 0xFF back-to-back, pulsing ack after each valid -> observe 0x00 then 0xFF; valid drops the cycle after each ack; overrun stays 0.
3. Drive a 4-cycle low glitch on uart_rxd -> busy high for at most 9 cycles and then 0; valid, frame_err and data unchanged.
4. Send 0x3C with a 0 stop bit, then hold the line low for 48 more cycles -> exactly one frame_err pulse; valid and data unchanged; busy remains 1 until rxd_s returns high.
5. Send 0x11 then 0x22 with no ack -> data=0x22, valid=1, overrun=1; one ack clears both. Repeat with ack coincident with the 0x22 load -> overrun stays 0.
6. Assert reset_n low during bit 3 of 0x5A -> all outputs 0 and busy 0 immediately. Release reset and send 0xC3 -> data=0xC3, valid=1, no errors.
